// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: definitions shared by the execute/writeback datapath and the
// branch unit.
//   - Default datapath widths (DATA_W_DEF, REG_AW_DEF)
//   - Condition-code encodings COND_AL..COND_NV
//   - ALU opcode encodings
//   - wb_entry_t: writeback entry {we, rd, data} at the default widths
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 4;

    // Condition codes evaluated against the architectural Z/N flags
    localparam logic [2:0] COND_AL = 3'd0;  // always
    localparam logic [2:0] COND_EQ = 3'd1;  // Z
    localparam logic [2:0] COND_NE = 3'd2;  // !Z
    localparam logic [2:0] COND_MI = 3'd3;  // N
    localparam logic [2:0] COND_PL = 3'd4;  // !N
    localparam logic [2:0] COND_GT = 3'd5;  // !Z & !N
    localparam logic [2:0] COND_LE = 3'd6;  // Z | N
    localparam logic [2:0] COND_NV = 3'd7;  // never

    // ALU opcodes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_SHR = 4'd6;
    localparam logic [3:0] ALU_MOV = 4'd7;

    typedef struct packed {
        logic                  we;
        logic [REG_AW_DEF-1:0] rd;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/cond_check.sv
// ---------------------------------------------------------------------------
// cond_check: purely combinational condition-code evaluator.
//   cond [2:0] in  : condition code (COND_*)
//   z          in  : zero flag
//   n          in  : negative flag
//   pass       out : 1 when the condition holds for the given flags
// Shared by the writeback stage and the branch unit.
// ---------------------------------------------------------------------------
module cond_check
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       z,
    input  logic       n,
    output logic       pass
);

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_AL: pass = 1'b1;
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_GT: pass = ~z & ~n;
            COND_LE: pass = z | n;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ---------------------------------------------------------------------------
// alu_writeback_stage: execute-to-writeback stage behind the ALU.
//   Captures the ALU result with a valid/ready handshake into a 2-entry skid
//   buffer (head output register + one skid register), owns the architectural
//   Z/N flags and gates the register-file write enable with the instruction
//   condition code.
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   in_valid, in_ready              upstream handshake (in_ready registered)
//   in_result, in_z, in_n, in_set   ALU result, raw flags, flag-update request
//   in_cond, in_we, in_rd           condition code, write request, dest index
//   wb_valid, wb_ready              register-file handshake
//   wb_we, wb_rd, wb_data           gated write enable, dest index, data
//   flag_z, flag_n                  architectural flags
// ---------------------------------------------------------------------------
module alu_writeback_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_z,
    input  logic              in_n,
    input  logic              in_set,
    input  logic [2:0]        in_cond,
    input  logic              in_we,
    input  logic [REG_AW-1:0] in_rd,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_z,
    output logic              flag_n
);

    // Entry layout follows wb_entry_t but at this instance's widths.
    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t     head_reg, head_next;
    entry_t     skid_reg, skid_next;
    entry_t     new_entry;
    logic [1:0] occ_reg, occ_next;
    logic       flag_z_reg, flag_z_next;
    logic       flag_n_reg, flag_n_next;
    logic       in_ready_reg, in_ready_next;

    logic       accept;
    logic       drain;
    logic       cond_pass;

    // Condition is judged against the flags as they stood before this edge,
    // so back-to-back instructions see a flag update one cycle later.
    cond_check u_cond_check (
        .cond (in_cond),
        .z    (flag_z_reg),
        .n    (flag_n_reg),
        .pass (cond_pass)
    );

    assign accept = in_valid & in_ready_reg;
    assign drain  = (occ_reg != 2'd0) & wb_ready;

    // Failed-condition instructions still travel through the buffer so the
    // handshake stays one-for-one; only their write enable is suppressed.
    always_comb begin
        new_entry      = '0;
        new_entry.we   = in_we & cond_pass;
        new_entry.rd   = in_rd;
        new_entry.data = in_result;
    end

    always_comb begin
        occ_next    = occ_reg;
        head_next   = head_reg;
        skid_next   = skid_reg;
        flag_z_next = flag_z_reg;
        flag_n_next = flag_n_reg;

        case ({accept, drain})
            2'b10: begin
                occ_next = occ_reg + 2'd1;
                if (occ_reg == 2'd0) begin
                    head_next = new_entry;
                end else begin
                    skid_next = new_entry;
                end
            end
            2'b01: begin
                occ_next = occ_reg - 2'd1;
                // With one entry the head simply empties and keeps its
                // contents visible on wb_rd/wb_data.
                if (occ_reg == 2'd2) begin
                    head_next = skid_reg;
                end
            end
            2'b11: begin
                // Only reachable at occupancy 1: head drains and refills.
                head_next = new_entry;
            end
            default: begin
            end
        endcase

        if (accept && in_set && cond_pass) begin
            flag_z_next = in_z;
            flag_n_next = in_n;
        end

        in_ready_next = (occ_next != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg     <= '0;
            skid_reg     <= '0;
            occ_reg      <= 2'd0;
            flag_z_reg   <= 1'b0;
            flag_n_reg   <= 1'b0;
            in_ready_reg <= 1'b0;
        end else begin
            head_reg     <= head_next;
            skid_reg     <= skid_next;
            occ_reg      <= occ_next;
            flag_z_reg   <= flag_z_next;
            flag_n_reg   <= flag_n_next;
            in_ready_reg <= in_ready_next;
        end
    end

    assign in_ready = in_ready_reg;
    assign wb_valid = (occ_reg != 2'd0);
    assign wb_we    = head_reg.we & wb_valid;
    assign wb_rd    = head_reg.rd;
    assign wb_data  = head_reg.data;
    assign flag_z   = flag_z_reg;
    assign flag_n   = flag_n_reg;

endmodule

// File: tb/tb_alu_writeback_stage.sv
`timescale 1ns/1ps
module tb_alu_writeback_stage;
    import cpu_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_z;
    logic              in_n;
    logic              in_set;
    logic [2:0]        in_cond;
    logic              in_we;
    logic [REG_AW-1:0] in_rd;
    logic              wb_valid;
    logic              wb_ready;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              flag_z;
    logic              flag_n;

    alu_writeback_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_z      (in_z),
        .in_n      (in_n),
        .in_set    (in_set),
        .in_cond   (in_cond),
        .in_we     (in_we),
        .in_rd     (in_rd),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .flag_z    (flag_z),
        .flag_n    (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: in-order queue of pending writes ----
    typedef struct {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              mq[$];
    logic              m_z, m_n, m_ready;
    logic [REG_AW-1:0] m_last_rd;
    logic [DATA_W-1:0] m_last_data;
    logic [DATA_W-1:0] drain_log[$];

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic cond_ok(input logic [2:0] c, input logic z, input logic n);
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n;
            3'd4: return !n;
            3'd5: return !z && !n;
            3'd6: return z || n;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_z = 1'b0; m_n = 1'b0; m_ready = 1'b0;
        m_last_rd = '0; m_last_data = '0;
    endtask

    task automatic check_all();
        chk("wb_valid", wb_valid, mq.size() > 0);
        chk("in_ready", in_ready, m_ready);
        chk("flag_z", flag_z, m_z);
        chk("flag_n", flag_n, m_n);
        chk("wb_we", wb_we, (mq.size() > 0) ? mq[0].we : 1'b0);
        chk("wb_rd", wb_rd, m_last_rd);
        chk("wb_data", wb_data, m_last_data);
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare.
    task automatic step(input logic v, input logic [DATA_W-1:0] res, input logic z,
                        input logic n, input logic set, input logic [2:0] cond,
                        input logic we, input logic [REG_AW-1:0] rd, input logic wbr);
        logic acc, drn, ok;
        ent_t e;
        in_valid = v; in_result = res; in_z = z; in_n = n; in_set = set;
        in_cond = cond; in_we = we; in_rd = rd; wb_ready = wbr;
        #1;
        if (wb_valid && wb_ready) drain_log.push_back(wb_data);
        acc = v && m_ready;
        drn = (mq.size() > 0) && wbr;
        ok  = cond_ok(cond, m_z, m_n);
        @(posedge clk);
        if (drn) void'(mq.pop_front());
        if (acc) begin
            e.we = we && ok; e.rd = rd; e.data = res;
            mq.push_back(e);
            if (set && ok) begin m_z = z; m_n = n; end
        end
        m_ready = (mq.size() != 2);
        if (mq.size() > 0) begin m_last_rd = mq[0].rd; m_last_data = mq[0].data; end
        #1;
        check_all();
    endtask

    task automatic idle(input logic wbr);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, COND_AL, 1'b0, '0, wbr);
    endtask

    // ---------------- condition-code table ----------------
    typedef struct {
        logic       z;
        logic       n;
        logic [2:0] cond;
        logic       exp_we;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, COND_AL, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, COND_EQ, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, COND_EQ, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, COND_NE, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, COND_NE, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, COND_MI, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, COND_MI, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, COND_PL, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, COND_PL, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, COND_GT, 1'b1};
        vecs[10] = '{1'b1, 1'b0, COND_GT, 1'b0};
        vecs[11] = '{1'b0, 1'b1, COND_GT, 1'b0};
        vecs[12] = '{1'b0, 1'b0, COND_LE, 1'b0};
        vecs[13] = '{1'b1, 1'b0, COND_LE, 1'b1};
        vecs[14] = '{1'b0, 1'b1, COND_LE, 1'b1};
        vecs[15] = '{1'b1, 1'b1, COND_NV, 1'b0};

        rst_n = 1'b0;
        in_valid = 0; in_result = '0; in_z = 0; in_n = 0; in_set = 0;
        in_cond = '0; in_we = 0; in_rd = '0; wb_ready = 0;
        model_reset();

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_in_ready_low", in_ready, 1'b0);
        rst_n = 1'b1;
        idle(1'b1);
        chk("rst_in_ready_after_release", in_ready, 1'b1);

        // ---- flag chain ----
        step(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, COND_AL, 1'b0, 4'd0, 1'b1);
        step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, COND_EQ, 1'b1, 4'd3, 1'b1);
        chk("chain_we", wb_we, 1'b1);
        chk("chain_rd", wb_rd, 4'd3);
        chk("chain_data", wb_data, 32'h55);
        chk("chain_flag_z", flag_z, 1'b1);
        idle(1'b1);

        // ---- condition fail ----
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, COND_AL, 1'b0, 4'd0, 1'b1);
        step(1'b1, 32'h77, 1'b1, 1'b0, 1'b1, COND_EQ, 1'b1, 4'd2, 1'b1);
        chk("cfail_valid", wb_valid, 1'b1);
        chk("cfail_we", wb_we, 1'b0);
        chk("cfail_rd", wb_rd, 4'd2);
        chk("cfail_flag_z", flag_z, 1'b0);
        idle(1'b1);

        // ---- N flag, MI / PL / NV ----
        step(1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1, COND_AL, 1'b0, 4'd0, 1'b1);
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, COND_MI, 1'b1, 4'd4, 1'b1);
        chk("mi_we", wb_we, 1'b1);
        step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, COND_PL, 1'b1, 4'd5, 1'b1);
        chk("pl_we", wb_we, 1'b0);
        step(1'b1, 32'h33, 1'b1, 1'b0, 1'b1, COND_NV, 1'b1, 4'd6, 1'b1);
        chk("nv_we", wb_we, 1'b0);
        chk("nv_flag_z", flag_z, 1'b0);
        chk("nv_flag_n", flag_n, 1'b1);
        idle(1'b1);

        // ---- table: set flags, then test one condition ----
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h0, vecs[i].z, vecs[i].n, 1'b1, COND_AL, 1'b0, 4'd0, 1'b1);
            step(1'b1, 32'hA0 + i, 1'b0, 1'b0, 1'b0, vecs[i].cond, 1'b1, 4'(i), 1'b1);
            chk($sformatf("tbl%0d_we", i), wb_we, vecs[i].exp_we);
            chk($sformatf("tbl%0d_data", i), wb_data, 32'hA0 + i);
        end
        idle(1'b1);
        idle(1'b1);

        // ---- backpressure ----
        drain_log.delete();
        step(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, COND_AL, 1'b1, 4'd1, 1'b0);
        chk("bp_ready_after_1", in_ready, 1'b1);
        step(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, COND_AL, 1'b1, 4'd1, 1'b0);
        chk("bp_ready_after_2", in_ready, 1'b0);
        step(1'b1, 32'h3, 1'b0, 1'b0, 1'b0, COND_AL, 1'b1, 4'd1, 1'b0);
        chk("bp_hold_data", wb_data, 32'h1);
        chk("bp_hold_ready", in_ready, 1'b0);
        for (int k = 0; k < 6 && m_ready == 1'b0; k++)
            step(1'b1, 32'h3, 1'b0, 1'b0, 1'b0, COND_AL, 1'b1, 4'd1, 1'b1);
        step(1'b1, 32'h3, 1'b0, 1'b0, 1'b0, COND_AL, 1'b1, 4'd1, 1'b1);
        repeat (3) idle(1'b1);
        chk("bp_drain_count", drain_log.size(), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("bp_drain%0d", k), (k < drain_log.size()) ? drain_log[k] : 32'hDEAD, k + 1);

        // ---- full throughput ----
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, COND_AL, 1'b1, 4'd7, 1'b1);
            chk($sformatf("tp%0d_valid", i), wb_valid, 1'b1);
            chk($sformatf("tp%0d_ready", i), in_ready, 1'b1);
            chk($sformatf("tp%0d_data", i), wb_data, 32'(i));
        end
        idle(1'b1);

        // ---- reset mid-stream ----
        step(1'b1, 32'hAA, 1'b1, 1'b1, 1'b1, COND_AL, 1'b1, 4'd8, 1'b0);
        step(1'b1, 32'hBB, 1'b0, 1'b0, 1'b0, COND_AL, 1'b1, 4'd9, 1'b0);
        chk("mid_full", in_ready, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("mid_rst_valid", wb_valid, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b0);
        chk("mid_rst_flags", {flag_z, flag_n}, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drain_log.delete();
        idle(1'b1);
        chk("mid_release_ready", in_ready, 1'b1);
        idle(1'b1);
        chk("mid_no_stale", drain_log.size(), 0);

        // ---- randomized against the model ----
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 1'($urandom),
                 1'($urandom), 3'($urandom), 1'($urandom), 4'($urandom),
                 1'($urandom_range(0, 2) != 0));
        end
        repeat (3) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
